// File: rtl/sys_array_input_skewer_pkg.sv
// Shared types and helpers for the systolic-array input feeder.
package sys_array_pkg;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    FLUSH,
    DONE
  } feed_state_t;

  // Active column count: 0 means a single column, anything wider than the array saturates.
  function automatic logic [15:0] clamp_len(input logic [15:0] cfg, input logic [15:0] max);
    if (cfg == 16'd0) return 16'd1;
    if (cfg > max) return max;
    return cfg;
  endfunction

endpackage

// File: rtl/sys_array_input_skewer_skew_delay_line.sv
// Per-lane delay line behind the shared stage-0 register; DEPTH==0 is a wire.
module skew_delay_line #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [DATA_WIDTH-1:0] data_o
);

  generate
    if (DEPTH == 0) begin : g_pass
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ reset;
      assign data_o = data_i;
    end else begin : g_shift
      logic [DATA_WIDTH-1:0] sr_q [DEPTH];

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int i = 0; i < DEPTH; i++) sr_q[i] <= '0;
        end else begin
          sr_q[0] <= data_i;
          for (int i = 1; i < DEPTH; i++) sr_q[i] <= sr_q[i-1];
        end
      end

      assign data_o = sr_q[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/sys_array_input_skewer.sv
// Feeds the systolic array: accepts vectors on valid/ready and drives them as a
// diagonal wavefront (lane j delayed j cycles), with zero bubbles and a flush tail.
module sys_array_input_skewer
  import sys_array_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int ARRAY_MAX_L = 10
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    weights_load,
  input  logic [15:0]                             cfg_len,
  input  logic                                    in_valid,
  output logic                                    in_ready,
  input  logic                                    in_last,
  input  logic [0:ARRAY_MAX_L-1][DATA_WIDTH-1:0]  in_data,
  output logic [0:ARRAY_MAX_L-1][DATA_WIDTH-1:0]  input_data,
  output logic                                    wave_valid,
  output logic                                    busy,
  output logic                                    done
);

  localparam int LEN_W = $clog2(ARRAY_MAX_L + 1);

  feed_state_t state_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] flush_cnt_q;
  logic [LEN_W-1:0] len_new;
  logic [LEN_W-1:0] len_eff;
  logic [0:ARRAY_MAX_L-1][DATA_WIDTH-1:0] s0_q;
  logic [0:ARRAY_MAX_L-1][DATA_WIDTH-1:0] s0_d;
  logic wave_valid_q;
  logic done_q;
  logic accept;

  // The first beat of a stream uses the live cfg_len; later beats use the latched length.
  assign len_new = LEN_W'(clamp_len(cfg_len, 16'(ARRAY_MAX_L)));
  assign len_eff = (state_q == IDLE) ? len_new : len_q;

  assign in_ready = !reset && !weights_load && ((state_q == IDLE) || (state_q == STREAM));
  assign accept   = in_valid && in_ready;

  always_comb begin
    s0_d = '0;
    if (accept) begin
      for (int j = 0; j < ARRAY_MAX_L; j++) begin
        if (j < int'(len_eff)) s0_d[j] = in_data[j];
      end
    end
  end

  // Stage 0: shared wavefront register, FSM and control flops
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      len_q        <= LEN_W'(1);
      flush_cnt_q  <= '0;
      s0_q         <= '0;
      wave_valid_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      s0_q         <= s0_d;
      wave_valid_q <= accept;
      done_q       <= 1'b0;
      case (state_q)
        IDLE, STREAM: begin
          if (accept) begin
            if (state_q == IDLE) len_q <= len_new;
            if (!in_last) begin
              state_q <= STREAM;
            end else if (len_eff == LEN_W'(1)) begin
              state_q <= DONE;
            end else begin
              state_q     <= FLUSH;
              flush_cnt_q <= len_eff - LEN_W'(1);
            end
          end
        end
        FLUSH: begin
          flush_cnt_q <= flush_cnt_q - LEN_W'(1);
          if (flush_cnt_q == LEN_W'(1)) state_q <= DONE;
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign wave_valid = wave_valid_q;
  assign done       = done_q;
  assign busy       = (state_q == STREAM) || (state_q == FLUSH) || (state_q == DONE);

  // Stages 1..L-1: lane j adds j more registers after stage 0
  generate
    for (genvar j = 0; j < ARRAY_MAX_L; j++) begin : g_lane
      skew_delay_line #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (j)
      ) u_delay (
        .clk   (clk),
        .reset (reset),
        .data_i(s0_q[j]),
        .data_o(input_data[j])
      );
    end
  endgenerate

endmodule

// File: tb/tb_sys_array_input_skewer.sv
// Bench for sys_array_input_skewer: directed and random streams against a wavefront history model.
module tb_sys_array_input_skewer;

  localparam int DW = 8;
  localparam int L  = 4;
  localparam int HN = 8192;

  logic clk = 1'b0;
  logic reset;
  logic weights_load;
  logic [15:0] cfg_len;
  logic in_valid;
  logic in_ready;
  logic in_last;
  logic [0:L-1][DW-1:0] in_data;
  logic [0:L-1][DW-1:0] input_data;
  logic wave_valid;
  logic busy;
  logic done;

  sys_array_input_skewer #(
    .DATA_WIDTH (DW),
    .ARRAY_MAX_L(L)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .weights_load(weights_load),
    .cfg_len     (cfg_len),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_last     (in_last),
    .in_data     (in_data),
    .input_data  (input_data),
    .wave_valid  (wave_valid),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: hist[n] is the masked vector accepted at edge n (zero if none);
  // lane j after edge n shows hist[n-j][j].
  int n = 0;
  logic [0:L-1][DW-1:0] hist [HN];
  bit acc_h [HN];
  bit active;
  int len_m;
  int last_edge;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s (edge %0d): observed %0h expected %0h", tag, n, got, exp);
    end
  endtask

  function automatic int clampm(input int c);
    if (c == 0) return 1;
    if (c > L) return L;
    return c;
  endfunction

  function automatic logic [0:L-1][DW-1:0] vec4(input int a, input int b, input int c, input int d);
    return {8'(a), 8'(b), 8'(c), 8'(d)};
  endfunction

  function automatic bit exp_ready(input bit wl);
    if (reset || wl) return 1'b0;
    if (last_edge >= 0 && n >= last_edge && n <= last_edge + len_m - 1) return 1'b0;
    return 1'b1;
  endfunction

  task automatic check_outputs();
    logic [0:L-1][DW-1:0] e;
    e = '0;
    for (int j = 0; j < L; j++) if (n - j >= 0) e[j] = hist[n-j][j];
    check("input_data", 64'(input_data), 64'(e));
    check("wave_valid", 64'(wave_valid), 64'(acc_h[n]));
    check("done", 64'(done), 64'(last_edge >= 0 && n == last_edge + len_m));
    check("busy", 64'(busy), 64'(active || (last_edge >= 0 && n <= last_edge + len_m - 1)));
  endtask

  task automatic step(input bit v, input bit last, input bit wl,
                      input logic [0:L-1][DW-1:0] d, input logic [15:0] cfg);
    bit r;
    bit a;
    in_valid     = v;
    in_last      = last;
    weights_load = wl;
    in_data      = d;
    cfg_len      = cfg;
    #1;
    r = exp_ready(wl);
    check("in_ready", 64'(in_ready), 64'(r));
    a = v && r;
    @(posedge clk);
    #1;
    n++;
    if (n >= HN) begin
      $display("FAIL history_overflow: edge %0d reached limit %0d", n, HN);
      $fatal(1);
    end
    if (a) begin
      if (!active) begin
        active    = 1'b1;
        len_m     = clampm(int'(cfg));
        last_edge = -1;
      end
      for (int j = 0; j < L; j++) hist[n][j] = (j < len_m) ? d[j] : 8'd0;
      acc_h[n] = 1'b1;
      if (last) begin
        active    = 1'b0;
        last_edge = n;
      end
    end else begin
      hist[n]  = '0;
      acc_h[n] = 1'b0;
    end
    check_outputs();
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(1'b0, 1'b0, 1'b0, '0, 16'd0);
  endtask

  task automatic do_reset(input int cycles);
    reset    = 1'b1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    weights_load = 1'b0;
    #1;
    check("rst_in_ready", 64'(in_ready), 64'(0));
    check("rst_input_data", 64'(input_data), 64'(0));
    check("rst_wave_valid", 64'(wave_valid), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk);
      #1;
      n++;
      hist[n]  = '0;
      acc_h[n] = 1'b0;
    end
    for (int k = 0; k < L; k++) if (n - k >= 0) hist[n-k] = '0;
    active    = 1'b0;
    last_edge = -1;
    len_m     = 1;
    reset     = 1'b0;
  endtask

  int k_left;
  int budget;
  logic [15:0] rcfg;
  bit rv;
  bit rwl;

  initial begin
    for (int i = 0; i < HN; i++) begin
      hist[i]  = '0;
      acc_h[i] = 1'b0;
    end
    active = 1'b0; last_edge = -1; len_m = 1;
    in_data = '0; cfg_len = 16'd0;
    do_reset(2);

    // Three back-to-back full-width beats.
    step(1, 0, 0, vec4(1, 2, 3, 4), 16'd4);
    step(1, 0, 0, vec4(5, 6, 7, 8), 16'd4);
    step(1, 1, 0, vec4(9, 10, 11, 12), 16'd4);
    idle(6);

    // Single beat with len 2: lanes 2,3 masked.
    step(1, 1, 0, vec4(7, 7, 7, 7), 16'd2);
    idle(4);

    // Two-cycle valid gap mid-stream.
    step(1, 0, 0, vec4(8'h11, 8'h12, 8'h13, 8'h14), 16'd4);
    step(1, 0, 0, vec4(8'h21, 8'h22, 8'h23, 8'h24), 16'd4);
    step(0, 0, 0, vec4(8'hee, 8'hee, 8'hee, 8'hee), 16'd4);
    step(0, 0, 0, vec4(8'hee, 8'hee, 8'hee, 8'hee), 16'd4);
    step(1, 0, 0, vec4(8'h31, 8'h32, 8'h33, 8'h34), 16'd4);
    step(1, 1, 0, vec4(8'h41, 8'h42, 8'h43, 8'h44), 16'd4);
    idle(6);

    // weights_load held three cycles with valid data offered.
    step(1, 0, 0, vec4(8'ha1, 8'ha2, 8'ha3, 8'ha4), 16'd3);
    step(1, 0, 1, vec4(8'hb1, 8'hb2, 8'hb3, 8'hb4), 16'd3);
    step(1, 0, 1, vec4(8'hb1, 8'hb2, 8'hb3, 8'hb4), 16'd3);
    step(1, 0, 1, vec4(8'hb1, 8'hb2, 8'hb3, 8'hb4), 16'd3);
    step(1, 0, 0, vec4(8'hb1, 8'hb2, 8'hb3, 8'hb4), 16'd9);
    step(1, 1, 0, vec4(8'hc1, 8'hc2, 8'hc3, 8'hc4), 16'd9);
    idle(5);

    // cfg_len clamping: 0 -> 1 column, 20 -> 4 columns.
    step(1, 0, 0, vec4(8'h51, 8'h52, 8'h53, 8'h54), 16'd0);
    step(1, 1, 0, vec4(8'h61, 8'h62, 8'h63, 8'h64), 16'd0);
    idle(3);
    step(1, 0, 0, vec4(8'h71, 8'h72, 8'h73, 8'h74), 16'd20);
    step(1, 1, 0, vec4(8'h81, 8'h82, 8'h83, 8'h84), 16'd20);
    idle(6);

    // Reset asserted during the flush tail.
    step(1, 0, 0, vec4(8'h91, 8'h92, 8'h93, 8'h94), 16'd4);
    step(1, 1, 0, vec4(8'h95, 8'h96, 8'h97, 8'h98), 16'd4);
    step(0, 0, 0, '0, 16'd4);
    do_reset(2);
    idle(4);
    step(1, 0, 0, vec4(8'hd1, 8'hd2, 8'hd3, 8'hd4), 16'd3);
    step(1, 1, 0, vec4(8'he1, 8'he2, 8'he3, 8'he4), 16'd3);
    idle(5);

    // Random streams with random valid, weights_load and mid-stream cfg changes.
    for (int s = 0; s < 6; s++) begin
      k_left = $urandom_range(1, 8);
      budget = 200;
      rcfg   = 16'($urandom_range(0, 6));
      while (k_left > 0 && budget > 0) begin
        rv  = ($urandom_range(0, 3) != 0);
        rwl = ($urandom_range(0, 6) == 0);
        step(rv, k_left == 1, rwl, $urandom, rcfg ^ 16'($urandom_range(0, 3)));
        if (acc_h[n]) k_left--;
        budget--;
      end
      checks++;
      assert (k_left == 0) else begin
        errors++;
        $error("FAIL stream_budget: observed %0d beats left expected 0", k_left);
      end
      idle($urandom_range(0, 7));
    end
    idle(6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1);
  end

endmodule
